// File: rtl/commit_scoreboard.sv
// In-order lockstep commit checker: buffers golden-model writebacks and
// compares each pipelined-core writeback against the oldest one.
module commit_scoreboard #(
  parameter int DATA_SIZE = 32,
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   CLEAR,
  input  logic                   ref_valid,
  input  logic [4:0]             ref_rd,
  input  logic [DATA_SIZE-1:0]   ref_data,
  input  logic                   dut_valid,
  input  logic [4:0]             dut_rd,
  input  logic [DATA_SIZE-1:0]   dut_data,
  output logic                   mismatch,
  output logic                   overflow,
  output logic                   underflow,
  output logic [4:0]             err_rd,
  output logic [DATA_SIZE-1:0]   err_exp,
  output logic [DATA_SIZE-1:0]   err_got,
  output logic [CNT_WIDTH-1:0]   match_count,
  output logic [CNT_WIDTH-1:0]   error_count,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef struct packed {
    logic [4:0]           rd;
    logic [DATA_SIZE-1:0] data;
  } entry_t;

  typedef enum logic {RUN, HALT} state_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  state_t        state, state_nxt;

  logic   run, push_req, pop_req, empty, full;
  logic   bypass, under, over;
  logic   do_push, do_pop, cmp, equal;
  entry_t head;

  always_comb begin
    run      = (state == RUN) && !CLEAR;
    push_req = ref_valid && (ref_rd != 5'd0);
    pop_req  = dut_valid && (dut_rd != 5'd0);
    empty    = (level == '0);
    full     = (level == FULL_LVL);
    bypass   = run && pop_req && push_req && empty;
    under    = run && pop_req && !push_req && empty;
    over     = run && push_req && !pop_req && full;
    do_push  = run && push_req && !bypass && !over;
    do_pop   = run && pop_req && !empty;
    cmp      = bypass || do_pop;
    head     = bypass ? entry_t'{ref_rd, ref_data} : mem[rd_ptr];
    equal    = (head.rd == dut_rd) && (head.data == dut_data);
  end

  always_comb begin
    state_nxt = state;
    if (CLEAR)
      state_nxt = RUN;
    else if (over || under)
      state_nxt = HALT;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      state <= RUN;
    else
      state <= state_nxt;
  end

  // Storage is not reset; validity is tracked by the pointers and level.
  always_ff @(posedge CLK) begin
    if (do_push)
      mem[wr_ptr] <= entry_t'{ref_rd, ref_data};
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (CLEAR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        level <= level + 1'b1;
      else if (do_pop && !do_push)
        level <= level - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mismatch    <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      err_rd      <= '0;
      err_exp     <= '0;
      err_got     <= '0;
      match_count <= '0;
      error_count <= '0;
    end else if (CLEAR) begin
      mismatch    <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      err_rd      <= '0;
      err_exp     <= '0;
      err_got     <= '0;
      match_count <= '0;
      error_count <= '0;
    end else begin
      if (over)
        overflow <= 1'b1;
      if (under)
        underflow <= 1'b1;
      if (cmp && equal && (match_count != '1))
        match_count <= match_count + 1'b1;
      if (cmp && !equal) begin
        if (error_count != '1)
          error_count <= error_count + 1'b1;
        // Only the first divergence is captured.
        if (!mismatch) begin
          mismatch <= 1'b1;
          err_rd   <= dut_rd;
          err_exp  <= head.data;
          err_got  <= dut_data;
        end
      end
    end
  end

  assign fifo_level = level;

endmodule

// File: tb/tb_commit_scoreboard.sv
// Directed self-checking bench for commit_scoreboard.
// Inputs change on the falling edge; outputs are sampled 1ns after rising.
module tb_commit_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        ref_valid = 1'b0;
  logic [4:0]  ref_rd = '0;
  logic [31:0] ref_data = '0;
  logic        dut_valid = 1'b0;
  logic [4:0]  dut_rd = '0;
  logic [31:0] dut_data = '0;
  logic        mismatch, overflow, underflow;
  logic [4:0]  err_rd;
  logic [31:0] err_exp, err_got;
  logic [15:0] match_count, error_count;
  logic [3:0]  fifo_level;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  commit_scoreboard #(.DATA_SIZE(32), .DEPTH(8), .CNT_WIDTH(16)) u_dut (
    .CLK(clk), .RESET_N(rst_n), .CLEAR(clear),
    .ref_valid(ref_valid), .ref_rd(ref_rd), .ref_data(ref_data),
    .dut_valid(dut_valid), .dut_rd(dut_rd), .dut_data(dut_data),
    .mismatch(mismatch), .overflow(overflow), .underflow(underflow),
    .err_rd(err_rd), .err_exp(err_exp), .err_got(err_got),
    .match_count(match_count), .error_count(error_count),
    .fifo_level(fifo_level)
  );

  task automatic cyc(input logic rv, input logic [4:0] rr,
                     input logic [31:0] rd_d, input logic dv,
                     input logic [4:0] dr, input logic [31:0] dd);
    @(negedge clk);
    ref_valid = rv; ref_rd = rr; ref_data = rd_d;
    dut_valid = dv; dut_rd = dr; dut_data = dd;
    @(posedge clk);
    #1;
    ref_valid = 1'b0; dut_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if ({mismatch, overflow, underflow} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {mismatch, overflow, underflow}); end
    n_chk++; if ({match_count, error_count} !== 32'd0) begin n_fail++; $display("FAIL reset_counts got %h exp 0", {match_count, error_count}); end
    n_chk++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_in_order();
    cyc(1, 5'd1, 32'd5, 0, 0, 0);
    cyc(1, 5'd2, 32'd8, 0, 0, 0);
    cyc(1, 5'd3, 32'd13, 0, 0, 0);
    n_chk++; if (fifo_level !== 4'd3) begin n_fail++; $display("FAIL inorder_peak got %0d exp 3", fifo_level); end
    cyc(0, 0, 0, 1, 5'd1, 32'd5);
    cyc(0, 0, 0, 1, 5'd2, 32'd8);
    cyc(0, 0, 0, 1, 5'd3, 32'd13);
    n_chk++; if (match_count !== 16'd3) begin n_fail++; $display("FAIL inorder_match got %0d exp 3", match_count); end
    n_chk++; if (error_count !== 16'd0) begin n_fail++; $display("FAIL inorder_err got %0d exp 0", error_count); end
    n_chk++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL inorder_level got %0d exp 0", fifo_level); end
    n_chk++; if ({mismatch, overflow, underflow} !== 3'b000) begin n_fail++; $display("FAIL inorder_flags got %b exp 000", {mismatch, overflow, underflow}); end
  endtask

  task automatic test_bypass();
    do_clear();
    cyc(1, 5'd5, 32'h2A, 1, 5'd5, 32'h2A);
    n_chk++; if (match_count !== 16'd1) begin n_fail++; $display("FAIL bypass_match got %0d exp 1", match_count); end
    n_chk++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL bypass_level got %0d exp 0", fifo_level); end
    n_chk++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL bypass_uflow got %b exp 0", underflow); end
  endtask

  task automatic test_mismatch();
    do_clear();
    cyc(1, 5'd4, 32'd21, 0, 0, 0);
    cyc(0, 0, 0, 1, 5'd4, 32'd22);
    n_chk++; if (mismatch !== 1'b1) begin n_fail++; $display("FAIL mm_flag got %b exp 1", mismatch); end
    n_chk++; if ({err_rd, err_exp, err_got} !== {5'd4, 32'd21, 32'd22}) begin n_fail++; $display("FAIL mm_ctx got %0d/%0d/%0d exp 4/21/22", err_rd, err_exp, err_got); end
    n_chk++; if (error_count !== 16'd1) begin n_fail++; $display("FAIL mm_err1 got %0d exp 1", error_count); end
    cyc(1, 5'd7, 32'd1, 0, 0, 0);
    cyc(0, 0, 0, 1, 5'd7, 32'd2);
    n_chk++; if (error_count !== 16'd2) begin n_fail++; $display("FAIL mm_err2 got %0d exp 2", error_count); end
    n_chk++; if ({err_rd, err_exp, err_got} !== {5'd4, 32'd21, 32'd22}) begin n_fail++; $display("FAIL mm_hold got %0d/%0d/%0d exp 4/21/22", err_rd, err_exp, err_got); end
    n_chk++; if (match_count !== 16'd0) begin n_fail++; $display("FAIL mm_match got %0d exp 0", match_count); end
    cyc(1, 5'd8, 32'd3, 1, 5'd8, 32'd3);
    n_chk++; if (match_count !== 16'd1) begin n_fail++; $display("FAIL mm_nohalt got %0d exp 1", match_count); end
  endtask

  task automatic test_overflow();
    do_clear();
    for (int i = 0; i < 8; i++) cyc(1, 5'(i + 1), 32'(100 + i), 0, 0, 0);
    n_chk++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL ovf_full got %0d exp 8", fifo_level); end
    cyc(1, 5'd9, 32'd200, 0, 0, 0);
    n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    cyc(0, 0, 0, 1, 5'd1, 32'd100);
    n_chk++; if (match_count !== 16'd0) begin n_fail++; $display("FAIL ovf_frozen got %0d exp 0", match_count); end
    n_chk++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL ovf_level got %0d exp 8", fifo_level); end
  endtask

  task automatic test_full_push_pop();
    do_clear();
    for (int i = 0; i < 8; i++) cyc(1, 5'(i + 1), 32'(100 + i), 0, 0, 0);
    cyc(1, 5'd9, 32'd200, 1, 5'd1, 32'd100);
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf got %b exp 0", overflow); end
    n_chk++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL fpp_level got %0d exp 8", fifo_level); end
    n_chk++; if (match_count !== 16'd1) begin n_fail++; $display("FAIL fpp_match got %0d exp 1", match_count); end
    cyc(0, 0, 0, 1, 5'd2, 32'd101);
    n_chk++; if ({match_count, 12'd0, fifo_level} !== {16'd2, 16'd7}) begin n_fail++; $display("FAIL fpp_next got %0d/%0d exp 2/7", match_count, fifo_level); end
  endtask

  task automatic test_underflow();
    do_clear();
    cyc(0, 0, 0, 1, 5'd6, 32'd9);
    n_chk++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL uf_flag got %b exp 1", underflow); end
    cyc(1, 5'd1, 32'd1, 0, 0, 0);
    n_chk++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL uf_halt got %0d exp 0", fifo_level); end
    @(negedge clk);
    clear = 1'b1; ref_valid = 1'b1; ref_rd = 5'd3; ref_data = 32'd7;
    @(posedge clk);
    #1;
    clear = 1'b0; ref_valid = 1'b0;
    n_chk++; if ({mismatch, overflow, underflow} !== 3'b000) begin n_fail++; $display("FAIL uf_clear got %b exp 000", {mismatch, overflow, underflow}); end
    n_chk++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL uf_clrwin got %0d exp 0", fifo_level); end
    cyc(1, 5'd6, 32'd9, 1, 5'd6, 32'd9);
    n_chk++; if (match_count !== 16'd1) begin n_fail++; $display("FAIL uf_resume got %0d exp 1", match_count); end
  endtask

  task automatic test_x0_reset();
    do_clear();
    cyc(1, 5'd0, 32'd1, 1, 5'd0, 32'd2);
    cyc(0, 0, 0, 1, 5'd0, 32'd3);
    n_chk++; if ({match_count, error_count} !== 32'd0) begin n_fail++; $display("FAIL x0_counts got %h exp 0", {match_count, error_count}); end
    n_chk++; if ({underflow, fifo_level} !== 5'd0) begin n_fail++; $display("FAIL x0_state got %b exp 0", {underflow, fifo_level}); end
    cyc(1, 5'd9, 32'd1, 0, 0, 0);
    cyc(0, 0, 0, 1, 5'd9, 32'd2);
    for (int i = 0; i < 3; i++) cyc(1, 5'(i + 10), 32'(i), 0, 0, 0);
    cyc(0, 0, 0, 1, 5'd0, 32'd0);
    n_chk++; if ({mismatch, fifo_level} !== {1'b1, 4'd3}) begin n_fail++; $display("FAIL x0_pre got %b/%0d exp 1/3", mismatch, fifo_level); end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL arst_level got %0d exp 0", fifo_level); end
    n_chk++; if ({mismatch, err_rd, err_exp, err_got, error_count} !== '0) begin n_fail++; $display("FAIL arst_out got %b/%0d/%0d exp 0", mismatch, err_rd, error_count); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 1, 5'd10, 32'd0);
    n_chk++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL arst_flush got %b exp 1", underflow); end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_bypass();
    test_mismatch();
    test_overflow();
    test_full_push_pop();
    test_underflow();
    test_x0_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
